// File: rtl/mtr_drv_pkg.sv
// Shared constants for the multi-channel motor PWM driver.
package mtr_drv_pkg;

  localparam int unsigned DEF_NCH       = 2;
  localparam int unsigned DEF_SPD_W     = 12;
  localparam int unsigned DEF_DEADTIME  = 32;
  localparam int unsigned DEF_BLANK_LEN = 128;
  localparam int unsigned DEF_OVR_LIMIT = 40;

  // Width of the saturating consecutive-faulted-period counter.
  localparam int unsigned FCNT_W = 6;

endpackage : mtr_drv_pkg

// File: rtl/nonoverlap.sv
// Per-channel dead-time generator: turns one raw PWM into a non-overlapping
// high-side / low-side pair, with an immediate kill path.
module nonoverlap
  import mtr_drv_pkg::*;
#(
  parameter int unsigned DEADTIME = DEF_DEADTIME
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic kill,
  output logic pwm1,
  output logic pwm2
);

  localparam int unsigned CW = $clog2(DEADTIME + 2);
  localparam logic [CW-1:0] DT = CW'(DEADTIME);

  logic [CW-1:0] hi_run;
  logic [CW-1:0] lo_run;
  logic [CW-1:0] hi_inc;
  logic [CW-1:0] lo_inc;

  // Run-length counters saturate once the dead time is satisfied.
  assign hi_inc = (hi_run == DT) ? hi_run : hi_run + CW'(1);
  assign lo_inc = (lo_run == DT) ? lo_run : lo_run + CW'(1);

  // A side turns on only after its raw level has held DEADTIME clocks; kill
  // drops both sides on the next edge and restarts the dead-time count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_run <= '0;
      lo_run <= '0;
      pwm1   <= 1'b0;
      pwm2   <= 1'b0;
    end else if (kill) begin
      hi_run <= '0;
      lo_run <= '0;
      pwm1   <= 1'b0;
      pwm2   <= 1'b0;
    end else begin
      hi_run <= raw ? hi_inc : '0;
      lo_run <= raw ? '0 : lo_inc;
      pwm1   <= raw & (hi_run == DT);
      pwm2   <= ~raw & (lo_run == DT);
    end
  end

endmodule : nonoverlap

// File: rtl/mtr_drv_nch.sv
// Multi-channel H-bridge PWM driver with dead time, overcurrent blanking and
// latched overcurrent shutdown.
module mtr_drv_nch
  import mtr_drv_pkg::*;
#(
  parameter int unsigned NCH       = DEF_NCH,
  parameter int unsigned SPD_W     = DEF_SPD_W,
  parameter int unsigned DEADTIME  = DEF_DEADTIME,
  parameter int unsigned BLANK_LEN = DEF_BLANK_LEN,
  parameter int unsigned OVR_LIMIT = DEF_OVR_LIMIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*SPD_W-1:0] spd,
  input  logic [NCH-1:0]     OVR_I,
  input  logic               clr_shtdwn,
  output logic [NCH-1:0]     PWM1,
  output logic [NCH-1:0]     PWM2,
  output logic               PWM_synch,
  output logic               ovr_I_blank,
  output logic [NCH-1:0]     fault_ch,
  output logic               OVR_I_shtdwn
);

  localparam int unsigned BLK_LO = DEADTIME;
  localparam int unsigned BLK_HI = DEADTIME + BLANK_LEN;

  logic [SPD_W-1:0]  cnt;
  logic [SPD_W-1:0]  cnt_nxt;
  logic              at_zero;
  logic              blank_nxt;

  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_nxt;
  logic [FCNT_W-1:0] fcnt_inc;
  logic              flt_per;
  logic              flt_per_nxt;
  logic [NCH-1:0]    fault_ch_nxt;
  logic              hold;
  logic              hold_nxt;
  logic              shtdwn_nxt;
  logic              hit;
  logic [NCH-1:0]    new_flt;
  logic              clr_ok;
  logic              clr_eff;
  logic              set_evt;
  logic              kill;

  assign cnt_nxt   = cnt + SPD_W'(1);
  assign at_zero   = (cnt == '0);
  assign blank_nxt = (32'(cnt_nxt) >= BLK_LO) && (32'(cnt_nxt) < BLK_HI);

  // Free-running period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  // Blank window and period strobe, registered so they line up with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_I_blank <= 1'b0;
      PWM_synch   <= 1'b0;
    end else begin
      ovr_I_blank <= blank_nxt;
      PWM_synch   <= (cnt_nxt == '0);
    end
  end

  // Per-channel duty shadowing, raw compare and dead-time stage.
  for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
    logic [SPD_W-1:0] duty_in;
    logic [SPD_W-1:0] shadow;
    logic [SPD_W-1:0] duty_eff;
    logic             raw;

    // Offset-binary: flipping the sign bit adds 2^(SPD_W-1).
    assign duty_in  = spd[k*SPD_W +: SPD_W] ^ {1'b1, {(SPD_W-1){1'b0}}};
    // The new duty already applies on the cnt==0 clock it is captured in.
    assign duty_eff = at_zero ? duty_in : shadow;
    assign raw      = (cnt < duty_eff);

    // Duty shadow updates only at the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       shadow <= '0;
      else if (at_zero) shadow <= duty_in;
    end

    nonoverlap #(
      .DEADTIME (DEADTIME)
    ) u_nonoverlap (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw),
      .kill  (kill),
      .pwm1  (PWM1[k]),
      .pwm2  (PWM2[k])
    );
  end

  assign new_flt  = OVR_I & {NCH{~ovr_I_blank}};
  assign hit      = |new_flt;
  assign clr_ok   = clr_shtdwn & ~(|OVR_I);
  assign fcnt_inc = (fcnt == '1) ? fcnt : fcnt + FCNT_W'(1);
  // Shutdown beats a simultaneous clear request.
  assign set_evt  = at_zero & flt_per & (fcnt_inc >= FCNT_W'(OVR_LIMIT));
  assign clr_eff  = clr_ok & ~set_evt;
  // Outputs drop on the same edge shutdown latches; after a clear they stay
  // off until the next period boundary.
  assign kill     = shtdwn_nxt | (hold & ~at_zero);

  // Fault bookkeeping, shutdown latch and restart hold next-state.
  always_comb begin
    fcnt_nxt     = fcnt;
    flt_per_nxt  = flt_per | hit;
    fault_ch_nxt = fault_ch | new_flt;
    shtdwn_nxt   = set_evt | (OVR_I_shtdwn & ~clr_eff);
    hold_nxt     = hold;
    if (at_zero) begin
      fcnt_nxt    = flt_per ? fcnt_inc : '0;
      flt_per_nxt = hit;
    end
    if (clr_eff) begin
      fcnt_nxt     = '0;
      flt_per_nxt  = 1'b0;
      fault_ch_nxt = '0;
    end
    if (shtdwn_nxt)   hold_nxt = 1'b1;
    else if (at_zero) hold_nxt = 1'b0;
  end

  // Fault state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt         <= '0;
      flt_per      <= 1'b0;
      fault_ch     <= '0;
      OVR_I_shtdwn <= 1'b0;
      hold         <= 1'b0;
    end else begin
      fcnt         <= fcnt_nxt;
      flt_per      <= flt_per_nxt;
      fault_ch     <= fault_ch_nxt;
      OVR_I_shtdwn <= shtdwn_nxt;
      hold         <= hold_nxt;
    end
  end

endmodule : mtr_drv_nch

// File: tb/tb_mtr_drv_nch.sv
// Directed bench for mtr_drv_nch with a 256-clock period, dead time 8 and a
// blank window of cnt in [8,40).
module tb_mtr_drv_nch;

  localparam int unsigned NCH = 2;
  localparam int unsigned SPD_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      spd = '0;
  logic [1:0]       OVR_I = '0;
  logic             clr_shtdwn = 1'b0;
  logic [1:0]       PWM1;
  logic [1:0]       PWM2;
  logic             PWM_synch;
  logic             ovr_I_blank;
  logic [1:0]       fault_ch;
  logic             OVR_I_shtdwn;

  int errors = 0;
  int checks = 0;
  int ovl_msgs = 0;

  int r_h1 [2];
  int r_h2 [2];
  int r_rise0, r_fall0, r_blk_n, r_blk_first, r_syn_n, r_shut_n;

  mtr_drv_nch #(
    .NCH(NCH), .SPD_W(SPD_W), .DEADTIME(8), .BLANK_LEN(32), .OVR_LIMIT(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spd(spd), .OVR_I(OVR_I), .clr_shtdwn(clr_shtdwn),
    .PWM1(PWM1), .PWM2(PWM2), .PWM_synch(PWM_synch), .ovr_I_blank(ovr_I_blank),
    .fault_ch(fault_ch), .OVR_I_shtdwn(OVR_I_shtdwn)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input int s0, input int s1);
    return {8'(s1), 8'(s0)};
  endfunction

  // High and low side of a channel must never be on together.
  always @(negedge clk) begin
    checks++;
    if ((PWM1 & PWM2) !== 2'b00) begin
      errors++;
      if (ovl_msgs < 10) $display("FAIL overlap: PWM1=%b PWM2=%b", PWM1, PWM2);
      ovl_msgs++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic wait_synch();
    int n = 0;
    while (PWM_synch !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (PWM_synch !== 1'b1) begin
      errors++;
      $display("FAIL wait_synch: no PWM_synch within 600 clocks");
    end
  endtask

  // Runs one full period starting at a cnt==0 negedge, applying optional
  // stimulus at given counter positions and recording output statistics.
  task automatic run_period(input int chg_at, input logic [15:0] chg_spd,
                            input int ovr_at, input logic [1:0] ovr_val,
                            input int clr_at);
    for (int k = 0; k < 2; k++) begin r_h1[k] = 0; r_h2[k] = 0; end
    r_rise0 = -1; r_fall0 = -1; r_blk_n = 0; r_blk_first = -1;
    r_syn_n = 0; r_shut_n = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == chg_at) spd = chg_spd;
      OVR_I = (i == ovr_at) ? ovr_val : 2'b00;
      clr_shtdwn = (i == clr_at);
      for (int k = 0; k < 2; k++) begin
        if (PWM1[k]) r_h1[k]++;
        if (PWM2[k]) r_h2[k]++;
      end
      if (PWM1[0] && r_rise0 < 0) r_rise0 = i;
      if (!PWM1[0] && r_rise0 >= 0 && r_fall0 < 0) r_fall0 = i;
      if (ovr_I_blank) begin
        r_blk_n++;
        if (r_blk_first < 0) r_blk_first = i;
      end
      if (PWM_synch) r_syn_n++;
      if (OVR_I_shtdwn) r_shut_n++;
      @(negedge clk);
    end
    OVR_I = 2'b00;
    clr_shtdwn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spd = pk(0, 64);
    repeat (3) @(negedge clk);
    checks++; if (PWM1 !== 2'b00) begin errors++; $display("FAIL reset_pwm1: got %b expected 00", PWM1); end
    checks++; if (PWM2 !== 2'b00) begin errors++; $display("FAIL reset_pwm2: got %b expected 00", PWM2); end
    checks++; if (PWM_synch !== 1'b0) begin errors++; $display("FAIL reset_synch: got %b expected 0", PWM_synch); end
    checks++; if (OVR_I_shtdwn !== 1'b0) begin errors++; $display("FAIL reset_shtdwn: got %b expected 0", OVR_I_shtdwn); end
    checks++; if (fault_ch !== 2'b00) begin errors++; $display("FAIL reset_fault_ch: got %b expected 00", fault_ch); end
    rst_n = 1'b1;
  endtask

  task automatic test_widths();
    int vec [4][6];
    vec = '{'{0, 64, 120, 120, 184, 56},
            '{-128, 127, 0, 256, 247, 0},
            '{-60, 5, 60, 180, 125, 115},
            '{-124, -120, 0, 244, 0, 240}};
    for (int v = 0; v < 4; v++) begin
      spd = pk(vec[v][0], vec[v][1]);
      wait_synch();
      run_period(-1, 16'h0, -1, 2'b00, -1);
      run_period(-1, 16'h0, -1, 2'b00, -1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (r_h1[k] !== vec[v][2+2*k]) begin errors++;
          $display("FAIL width_pwm1 v%0d ch%0d: got %0d expected %0d", v, k, r_h1[k], vec[v][2+2*k]); end
        checks++;
        if (r_h2[k] !== vec[v][3+2*k]) begin errors++;
          $display("FAIL width_pwm2 v%0d ch%0d: got %0d expected %0d", v, k, r_h2[k], vec[v][3+2*k]); end
      end
      checks++;
      if (r_syn_n !== 1) begin errors++; $display("FAIL synch_count v%0d: got %0d expected 1", v, r_syn_n); end
      if (v == 0) begin
        checks++; if (r_rise0 !== 9) begin errors++; $display("FAIL pwm1_rise: got %0d expected 9", r_rise0); end
        checks++; if (r_fall0 !== 129) begin errors++; $display("FAIL pwm1_fall: got %0d expected 129", r_fall0); end
        checks++; if (r_blk_n !== 32) begin errors++; $display("FAIL blank_len: got %0d expected 32", r_blk_n); end
        checks++; if (r_blk_first !== 8) begin errors++; $display("FAIL blank_start: got %0d expected 8", r_blk_first); end
      end
    end
  endtask

  task automatic test_midperiod();
    spd = pk(0, 0);
    wait_synch();
    run_period(-1, 16'h0, -1, 2'b00, -1);
    run_period(100, pk(64, 0), -1, 2'b00, -1);
    checks++; if (r_h1[0] !== 120) begin errors++; $display("FAIL mid_old_width: got %0d expected 120", r_h1[0]); end
    run_period(-1, 16'h0, -1, 2'b00, -1);
    checks++; if (r_h1[0] !== 184) begin errors++; $display("FAIL mid_new_width: got %0d expected 184", r_h1[0]); end
    checks++; if (r_h2[0] !== 56) begin errors++; $display("FAIL mid_new_pwm2: got %0d expected 56", r_h2[0]); end
    checks++; if (r_fall0 !== 193) begin errors++; $display("FAIL mid_new_fall: got %0d expected 193", r_fall0); end
  endtask

  task automatic test_blank();
    int shut_sum = 0;
    int at;
    spd = pk(0, 64);
    checks++; if (fault_ch !== 2'b00) begin errors++; $display("FAIL blank_pre_fault_ch: got %b expected 00", fault_ch); end
    for (int p = 0; p < 60; p++) begin
      at = (p % 3 == 0) ? 8 : ((p % 3 == 1) ? 20 : 39);
      run_period(-1, 16'h0, at, 2'b01, -1);
      shut_sum += r_shut_n;
    end
    checks++; if (shut_sum !== 0) begin errors++; $display("FAIL blank_shutdown_cycles: got %0d expected 0", shut_sum); end
    checks++; if (OVR_I_shtdwn !== 1'b0) begin errors++; $display("FAIL blank_shtdwn: got %b expected 0", OVR_I_shtdwn); end
    checks++; if (fault_ch !== 2'b00) begin errors++; $display("FAIL blank_fault_ch: got %b expected 00", fault_ch); end
  endtask

  task automatic test_fault_39();
    int shut_sum = 0;
    for (int p = 0; p < 39; p++) begin
      run_period(-1, 16'h0, 40, 2'b10, -1);
      shut_sum += r_shut_n;
    end
    run_period(-1, 16'h0, -1, 2'b00, -1);
    shut_sum += r_shut_n;
    run_period(-1, 16'h0, -1, 2'b00, -1);
    shut_sum += r_shut_n;
    checks++; if (shut_sum !== 0) begin errors++; $display("FAIL f39_shutdown_cycles: got %0d expected 0", shut_sum); end
    checks++; if (fault_ch !== 2'b10) begin errors++; $display("FAIL f39_fault_ch: got %b expected 10", fault_ch); end
  endtask

  task automatic test_shutdown();
    int shut_sum = 0;
    for (int p = 0; p < 40; p++) begin
      run_period(-1, 16'h0, 40, 2'b10, -1);
      shut_sum += r_shut_n;
    end
    checks++; if (shut_sum !== 0) begin errors++; $display("FAIL shut_early: got %0d expected 0", shut_sum); end
    checks++; if (OVR_I_shtdwn !== 1'b0) begin errors++; $display("FAIL shut_pre_edge: got %b expected 0", OVR_I_shtdwn); end
    clr_shtdwn = 1'b1;
    @(negedge clk);
    clr_shtdwn = 1'b0;
    checks++; if (OVR_I_shtdwn !== 1'b1) begin errors++; $display("FAIL shut_vs_clear: got %b expected 1", OVR_I_shtdwn); end
    checks++; if ({PWM1, PWM2} !== 4'b0000) begin errors++; $display("FAIL shut_pwm_off: got %b expected 0000", {PWM1, PWM2}); end
    checks++; if (fault_ch !== 2'b10) begin errors++; $display("FAIL shut_fault_ch: got %b expected 10", fault_ch); end
    wait_synch();
    run_period(-1, 16'h0, 40, 2'b10, -1);
    checks++; if (r_h1[0] + r_h1[1] + r_h2[0] + r_h2[1] !== 0) begin errors++;
      $display("FAIL shut_period_pwm: got %0d expected 0", r_h1[0] + r_h1[1] + r_h2[0] + r_h2[1]); end
    checks++; if (r_shut_n !== 256) begin errors++; $display("FAIL shut_held: got %0d expected 256", r_shut_n); end
  endtask

  task automatic test_clear();
    run_period(-1, 16'h0, 100, 2'b10, 100);
    checks++; if (OVR_I_shtdwn !== 1'b1) begin errors++; $display("FAIL clr_ignored: got %b expected 1", OVR_I_shtdwn); end
    run_period(-1, 16'h0, -1, 2'b00, 150);
    checks++; if (r_shut_n !== 151) begin errors++; $display("FAIL clr_cycle: got %0d expected 151", r_shut_n); end
    checks++; if (r_h1[0] + r_h1[1] + r_h2[0] + r_h2[1] !== 0) begin errors++;
      $display("FAIL clr_hold_off: got %0d expected 0", r_h1[0] + r_h1[1] + r_h2[0] + r_h2[1]); end
    checks++; if (fault_ch !== 2'b00) begin errors++; $display("FAIL clr_fault_ch: got %b expected 00", fault_ch); end
    run_period(-1, 16'h0, -1, 2'b00, -1);
    checks++; if (r_h1[0] !== 120) begin errors++; $display("FAIL resume_pwm1_ch0: got %0d expected 120", r_h1[0]); end
    checks++; if (r_h2[0] !== 119) begin errors++; $display("FAIL resume_pwm2_ch0: got %0d expected 119", r_h2[0]); end
    checks++; if (r_h1[1] !== 184) begin errors++; $display("FAIL resume_pwm1_ch1: got %0d expected 184", r_h1[1]); end
    checks++; if (r_h2[1] !== 55) begin errors++; $display("FAIL resume_pwm2_ch1: got %0d expected 55", r_h2[1]); end
    checks++; if (r_rise0 !== 9) begin errors++; $display("FAIL resume_rise: got %0d expected 9", r_rise0); end
  endtask

  task automatic test_reset_in_shutdown();
    for (int p = 0; p < 40; p++) run_period(-1, 16'h0, 40, 2'b10, -1);
    repeat (3) @(negedge clk);
    checks++; if (OVR_I_shtdwn !== 1'b1) begin errors++; $display("FAIL rs_pre_shtdwn: got %b expected 1", OVR_I_shtdwn); end
    rst_n = 1'b0;
    #1;
    checks++; if (OVR_I_shtdwn !== 1'b0) begin errors++; $display("FAIL rs_shtdwn: got %b expected 0", OVR_I_shtdwn); end
    checks++; if (fault_ch !== 2'b00) begin errors++; $display("FAIL rs_fault_ch: got %b expected 00", fault_ch); end
    checks++; if ({PWM1, PWM2, PWM_synch} !== 5'b00000) begin errors++;
      $display("FAIL rs_outputs: got %b expected 00000", {PWM1, PWM2, PWM_synch}); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_synch();
    run_period(-1, 16'h0, -1, 2'b00, -1);
    checks++; if (r_h1[0] !== 120 || r_h2[0] !== 120 || r_h1[1] !== 184 || r_h2[1] !== 56) begin errors++;
      $display("FAIL rs_restart_widths: got %0d/%0d/%0d/%0d expected 120/120/184/56", r_h1[0], r_h2[0], r_h1[1], r_h2[1]); end
    checks++; if (r_shut_n !== 0) begin errors++; $display("FAIL rs_restart_shtdwn: got %0d expected 0", r_shut_n); end
  endtask

  initial begin
    test_reset();
    test_widths();
    test_midperiod();
    wait_synch();
    test_blank();
    test_fault_39();
    test_shutdown();
    test_clear();
    test_reset_in_shutdown();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mtr_drv_nch
